cmd_seq: RTL and testbench
==========================

# cmd_seq

Command sequencer directly upstream of `snd_cmd`. On a single `go` pulse it walks a fixed table of command descriptors and issues each one to `snd_cmd` using `send`, `cmd_start` and `cmd_len`. After each command it waits for `resp_rcvd`. It retries a command that times out, and finishes with either a sticky `done` or a sticky `err` for the top level.

## Interface
- `NUM_CMDS`, default 4: number of table entries issued, 1..8.
- `TIMEOUT_CYC`, default 50000: cycles to wait for `resp_rcvd` after each `send`, minimum 2.
- `MAX_RETRY`, default 3: re-issues allowed per command after a timeout, 0..7.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in, 1: system clock, rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `go` in, 1: start-sequence request, sampled only in IDLE, DONE and ERROR.
- `resp_rcvd` in, 1: one-cycle pulse from `snd_cmd` when a 0x0A response arrives.
- `send` out, 1: one-cycle load strobe to `snd_cmd`.
- `cmd_start` out, 5: ROM start address of the current command.
- `cmd_len` out, 4: byte length of the current command.
- `cmd_idx` out, 3: index of the current table entry.
- `busy` out, 1: high in ISSUE and WAIT_RESP.
- `done` out, 1: sticky; the whole sequence has been acknowledged.
- `err` out, 1: sticky; retries were exhausted.

## Operation
- States: IDLE, ISSUE, WAIT_RESP, DONE, ERROR. Encoding comes from the package enum.
- IDLE, DONE or ERROR with `go`=1: `cmd_idx`←0, `retry_cnt`←0, `done`←0, `err`←0, next state ISSUE.
- ISSUE: `send`=1 for exactly this one cycle. `timer`←0. Next state WAIT_RESP unconditionally.
- WAIT_RESP: `timer` increments every cycle. Exits, in this order:
  - `resp_rcvd`=1 and `cmd_idx`==`NUM_CMDS`-1: go to DONE, `done`←1.
  - `resp_rcvd`=1 otherwise: `cmd_idx`+1, `retry_cnt`←0, go to ISSUE.
  - `timer`==`TIMEOUT_CYC`-1 with no response and `retry_cnt`<`MAX_RETRY`: `retry_cnt`+1, go to ISSUE with the same `cmd_idx`.
  - `timer`==`TIMEOUT_CYC`-1 with no response and `retry_cnt`==`MAX_RETRY`: go to ERROR, `err`←1.
- If `resp_rcvd` and the timeout coincide in the same cycle, the response wins.
- `resp_rcvd` is ignored in IDLE, ISSUE, DONE and ERROR.
- `go` is ignored while `busy`=1. There is no abort; only `rst` stops a sequence.
- `cmd_start` and `cmd_len` are read combinationally from package constants indexed by the registered `cmd_idx`. They are stable from ISSUE through the end of WAIT_RESP.
- Width rules:
  - `timer` is `$clog2(TIMEOUT_CYC)` bits, saturating-safe because it is cleared in ISSUE.
  - `retry_cnt` is 3 bits.
  - `cmd_idx` never exceeds `NUM_CMDS`-1.

## Timing
- Reset values: state IDLE, `send`=0, `busy`=0, `done`=0, `err`=0, `cmd_idx`=0, `timer`=0, `retry_cnt`=0. With `cmd_idx`=0, `cmd_start` and `cmd_len` show entry 0.
- `go` sampled at edge N: `send`=1 during cycle N+1. The first WAIT_RESP cycle is N+2.
- `resp_rcvd` sampled at edge M: the next `send` occurs in cycle M+1. For the last entry, `done`=1 from cycle M+1.
- Timeout: with no response, the re-issue `send` occurs `TIMEOUT_CYC`+1 cycles after the previous `send`.
- `send` is decoded from the state register only, so it is glitch-free and never high for two consecutive cycles.
- Reset mid-operation clears everything within the same cycle (asynchronous). No `send` is produced until a new `go`.

## Structure
- Package `cmd_seq_pkg` holds:
  - `state_t` enum.
  - `CMD_START[0:7]` (5-bit) and `CMD_LEN[0:7]` (4-bit) constant arrays.
  - Entries 0..3 are {0,3}, {3,5}, {8,4}, {12,6}; entries 4..7 are {0,0}.
- One sub-module, `resp_timer`: clear/enable counter with a terminal-count output `tc` at `TIMEOUT_CYC`-1. The FSM, `cmd_idx` and `retry_cnt` stay in `cmd_seq`.

## Test plan
All scenarios use `TIMEOUT_CYC`=20, `MAX_RETRY`=2, `NUM_CMDS`=4.
- Happy path: `go` pulse, `resp_rcvd` 5 cycles after each `send` → 4 `send` pulses with `cmd_start`/`cmd_len` = 0/3, 3/5, 8/4, 12/6; `done`=1 one cycle after the 4th response; `err`=0.
- Single timeout: no response to entry 1's first `send` → re-issue `send` 21 cycles later with `cmd_start`=3; respond → sequence continues; `done`=1.
- Retry exhaustion: never respond to entry 2 → 3 `send` pulses with `cmd_start`=8, then `err`=1 and `busy`=0; `done`=0.
- Coincidence: `resp_rcvd` in the exact `tc` cycle → advances to the next entry; no retry.
- Spurious inputs: `resp_rcvd` in IDLE and `go` in WAIT_RESP → no state change, no extra `send`.
- Reset mid-sequence: assert `rst` during WAIT_RESP of entry 2 → all outputs return to reset values immediately; a new `go` restarts at entry 0.

Source files
------------

// File: rtl/cmd_seq_pkg.sv
// Shared types and the fixed command descriptor table for the command sequencer.
package cmd_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RESP,
    DONE,
    ERROR
  } state_t;

  // Descriptor table: ROM start address and byte length per entry; unused entries are empty.
  localparam logic [4:0] CMD_START [0:7] = '{5'd0, 5'd3, 5'd8, 5'd12, 5'd0, 5'd0, 5'd0, 5'd0};
  localparam logic [3:0] CMD_LEN   [0:7] = '{4'd3, 4'd5, 4'd4, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0};

endpackage

// File: rtl/cmd_seq_resp_timer.sv
// Response timeout counter: cleared on each issue, counts while waiting,
// flags the last allowed wait cycle on tc.
module resp_timer #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TW-1:0] timer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (clear) begin
      timer <= '0;
    end else if (enable) begin
      timer <= timer + 1'b1;
    end
  end

  assign tc = (timer == TW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/cmd_seq.sv
// Command sequencer: walks the descriptor table, issues each entry to snd_cmd,
// waits for its response and retries on timeout, ending in sticky done or err.
module cmd_seq
  import cmd_seq_pkg::*;
#(
  parameter int NUM_CMDS    = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       resp_rcvd,
  output logic       send,
  output logic [4:0] cmd_start,
  output logic [3:0] cmd_len,
  output logic [2:0] cmd_idx,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] LAST_IDX  = 3'(NUM_CMDS - 1);
  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

  state_t     state;
  logic [2:0] retry_cnt;
  logic       tc;

  resp_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_resp_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (state == ISSUE),
    .enable(state == WAIT_RESP),
    .tc    (tc)
  );

  // A response takes priority over a timeout landing in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_idx   <= '0;
      retry_cnt <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (go) begin
            cmd_idx   <= '0;
            retry_cnt <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE: state <= WAIT_RESP;
        WAIT_RESP: begin
          if (resp_rcvd) begin
            if (cmd_idx == LAST_IDX) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              cmd_idx   <= cmd_idx + 1'b1;
              retry_cnt <= '0;
              state     <= ISSUE;
            end
          end else if (tc) begin
            if (retry_cnt < RETRY_MAX) begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= ISSUE;
            end else begin
              err   <= 1'b1;
              state <= ERROR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes come straight off the state register so they cannot glitch.
  assign send      = (state == ISSUE);
  assign busy      = (state == ISSUE) || (state == WAIT_RESP);
  assign cmd_start = CMD_START[cmd_idx];
  assign cmd_len   = CMD_LEN[cmd_idx];

endmodule

// File: tb/tb_cmd_seq.sv
// Scoreboard bench for cmd_seq: expected descriptors are queued as each
// sequence is launched and popped whenever the DUT strobes send.
module tb_cmd_seq;

  localparam int TO = 20;
  localparam int MR = 2;
  localparam int NC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       go;
  logic       resp_rcvd;
  logic       send;
  logic [4:0] cmd_start;
  logic [3:0] cmd_len;
  logic [2:0] cmd_idx;
  logic       busy;
  logic       done;
  logic       err;

  int n_pass  = 0;
  int n_total = 0;

  logic [12:0] sb[$];
  logic [4:0]  tb_start [4] = '{5'd0, 5'd3, 5'd8, 5'd12};
  logic [3:0]  tb_len   [4] = '{4'd3, 4'd5, 4'd4, 4'd6};

  cmd_seq #(
    .NUM_CMDS   (NC),
    .TIMEOUT_CYC(TO),
    .MAX_RETRY  (MR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .resp_rcvd(resp_rcvd),
    .send     (send),
    .cmd_start(cmd_start),
    .cmd_len  (cmd_len),
    .cmd_idx  (cmd_idx),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic push_cmd(input int i);
    sb.push_back({1'b1, 3'(i), tb_start[i], tb_len[i]});
  endtask

  function automatic logic [12:0] pop_exp();
    if (sb.size() == 0) return 13'h0;
    return sb.pop_front();
  endfunction

  function automatic logic [12:0] obs();
    return {send, cmd_idx, cmd_start, cmd_len};
  endfunction

  task automatic pulse_go();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic pulse_resp();
    resp_rcvd = 1'b1;
    @(negedge clk);
    resp_rcvd = 1'b0;
  endtask

  // Waits (bounded) until send is high in the current cycle.
  task automatic wait_send(input int max_cyc, output int waited);
    waited = 0;
    while (send !== 1'b1 && waited < max_cyc) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic count_sends(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (send === 1'b1) n++;
    end
  endtask

  task automatic test_reset();
    logic [15:0] got;
    int n;
    rst = 1'b1; go = 1'b0; resp_rcvd = 1'b0;
    repeat (3) @(negedge clk);
    got = {send, busy, done, err, cmd_idx, cmd_start, cmd_len};
    n_total++;
    if (got !== {4'b0, 3'd0, 5'd0, 4'd3}) $display("[TB] FAIL reset_values got %h expected %h", got, {4'b0, 3'd0, 5'd0, 4'd3});
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    resp_rcvd = 1'b1;
    count_sends(3, n);
    resp_rcvd = 1'b0;
    n_total++;
    if (n !== 0 || busy !== 1'b0) $display("[TB] FAIL idle_resp_ignored got sends=%0d busy=%b expected sends=0 busy=0", n, busy);
    else n_pass++;
  endtask

  task automatic test_happy();
    int w;
    logic [12:0] e, g;
    for (int i = 0; i < NC; i++) push_cmd(i);
    pulse_go();
    for (int i = 0; i < NC; i++) begin
      wait_send(40, w);
      e = pop_exp(); g = obs();
      n_total++;
      if (g !== e || w !== 0 || busy !== 1'b1) $display("[TB] FAIL happy_send%0d got %h wait=%0d busy=%b expected %h wait=0 busy=1", i, g, w, busy, e);
      else n_pass++;
      repeat (5) @(negedge clk);
      pulse_resp();
    end
    n_total++;
    if ({done, err, busy, send} !== 4'b1000) $display("[TB] FAIL happy_done got done/err/busy/send=%b expected 1000", {done, err, busy, send});
    else n_pass++;
  endtask

  task automatic test_single_timeout();
    int w;
    int exp_w;
    logic [12:0] e, g;
    push_cmd(0); push_cmd(1); push_cmd(1); push_cmd(2); push_cmd(3);
    pulse_go();
    for (int j = 0; j < 5; j++) begin
      exp_w = (j == 2) ? TO : 0;
      wait_send(40, w);
      e = pop_exp(); g = obs();
      n_total++;
      if (g !== e || w !== exp_w) $display("[TB] FAIL timeout_send%0d got %h wait=%0d expected %h wait=%0d", j, g, w, e, exp_w);
      else n_pass++;
      if (j == 1) @(negedge clk);
      else begin
        repeat (5) @(negedge clk);
        pulse_resp();
      end
    end
    n_total++;
    if ({done, err, busy} !== 3'b100) $display("[TB] FAIL timeout_done got done/err/busy=%b expected 100", {done, err, busy});
    else n_pass++;
  endtask

  task automatic test_retry_exhaust();
    int w;
    int exp_w;
    int n;
    logic [12:0] e, g;
    push_cmd(0); push_cmd(1); push_cmd(2); push_cmd(2); push_cmd(2);
    pulse_go();
    for (int j = 0; j < 5; j++) begin
      exp_w = (j >= 3) ? TO : 0;
      wait_send(40, w);
      e = pop_exp(); g = obs();
      n_total++;
      if (g !== e || w !== exp_w) $display("[TB] FAIL retry_send%0d got %h wait=%0d expected %h wait=%0d", j, g, w, e, exp_w);
      else n_pass++;
      if (j < 2) begin
        repeat (5) @(negedge clk);
        pulse_resp();
      end else @(negedge clk);
    end
    repeat (TO - 1) @(negedge clk);
    n_total++;
    if ({busy, err, send} !== 3'b100) $display("[TB] FAIL retry_last_wait got busy/err/send=%b expected 100", {busy, err, send});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({err, busy, done, send} !== 4'b1000) $display("[TB] FAIL retry_err got err/busy/done/send=%b expected 1000", {err, busy, done, send});
    else n_pass++;
    count_sends(30, n);
    n_total++;
    if (n !== 0 || err !== 1'b1) $display("[TB] FAIL retry_quiet got sends=%0d err=%b expected sends=0 err=1", n, err);
    else n_pass++;
  endtask

  task automatic test_coincidence();
    int w;
    logic [12:0] e, g;
    for (int i = 0; i < NC; i++) push_cmd(i);
    pulse_go();
    for (int j = 0; j < NC; j++) begin
      wait_send(40, w);
      e = pop_exp(); g = obs();
      n_total++;
      if (g !== e || w !== 0) $display("[TB] FAIL coinc_send%0d got %h wait=%0d expected %h wait=0", j, g, w, e);
      else n_pass++;
      if (j == 0) repeat (TO) @(negedge clk);
      else repeat (5) @(negedge clk);
      pulse_resp();
    end
    n_total++;
    if ({done, err, busy} !== 3'b100) $display("[TB] FAIL coinc_done got done/err/busy=%b expected 100", {done, err, busy});
    else n_pass++;
  endtask

  task automatic test_spurious();
    int w;
    int n;
    logic [12:0] e, g;
    resp_rcvd = 1'b1;
    count_sends(5, n);
    resp_rcvd = 1'b0;
    @(negedge clk);
    n_total++;
    if (n !== 0 || {done, busy} !== 2'b10) $display("[TB] FAIL spur_resp_done got sends=%0d done/busy=%b expected sends=0 done/busy=10", n, {done, busy});
    else n_pass++;
    for (int i = 0; i < NC; i++) push_cmd(i);
    pulse_go();
    for (int j = 0; j < NC; j++) begin
      wait_send(40, w);
      e = pop_exp(); g = obs();
      n_total++;
      if (g !== e || w !== 0) $display("[TB] FAIL spur_send%0d got %h wait=%0d expected %h wait=0", j, g, w, e);
      else n_pass++;
      if (j == 0) begin
        @(negedge clk);
        go = 1'b1;
        count_sends(8, n);
        go = 1'b0;
        n_total++;
        if (n !== 0 || cmd_idx !== 3'd0) $display("[TB] FAIL spur_go_busy got sends=%0d idx=%0d expected sends=0 idx=0", n, cmd_idx);
        else n_pass++;
        repeat (2) @(negedge clk);
      end else repeat (5) @(negedge clk);
      pulse_resp();
    end
    n_total++;
    if ({done, err} !== 2'b10) $display("[TB] FAIL spur_done got done/err=%b expected 10", {done, err});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int w;
    int n;
    logic [12:0] e, g;
    logic [15:0] r;
    for (int i = 0; i < 3; i++) push_cmd(i);
    pulse_go();
    for (int j = 0; j < 3; j++) begin
      wait_send(40, w);
      e = pop_exp(); g = obs();
      n_total++;
      if (g !== e || w !== 0) $display("[TB] FAIL rstmid_send%0d got %h wait=%0d expected %h wait=0", j, g, w, e);
      else n_pass++;
      if (j < 2) begin
        repeat (5) @(negedge clk);
        pulse_resp();
      end
    end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 r = {send, busy, done, err, cmd_idx, cmd_start, cmd_len};
    n_total++;
    if (r !== {4'b0, 3'd0, 5'd0, 4'd3}) $display("[TB] FAIL rstmid_async got %h expected %h", r, {4'b0, 3'd0, 5'd0, 4'd3});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    count_sends(10, n);
    n_total++;
    if (n !== 0) $display("[TB] FAIL rstmid_quiet got sends=%0d expected 0", n);
    else n_pass++;
    for (int i = 0; i < NC; i++) push_cmd(i);
    pulse_go();
    for (int j = 0; j < NC; j++) begin
      wait_send(40, w);
      e = pop_exp(); g = obs();
      n_total++;
      if (g !== e || w !== 0) $display("[TB] FAIL restart_send%0d got %h wait=%0d expected %h wait=0", j, g, w, e);
      else n_pass++;
      repeat (5) @(negedge clk);
      pulse_resp();
    end
    n_total++;
    if ({done, err, busy} !== 3'b100 || sb.size() !== 0) $display("[TB] FAIL restart_done got done/err/busy=%b left=%0d expected 100 left=0", {done, err, busy}, sb.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_happy();
    test_single_timeout();
    test_retry_exhaust();
    test_coincidence();
    test_spurious();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
